// File: rtl/mbledhesi_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// width helper for the bit counter.
package mbledhesi_serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    // The counter only has to reach n-1, and it is never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mbledhesi_1b.sv
// One-bit full adder cell, the arithmetic core of the serial adder.
module mbledhesi_1b (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_shuma,
    output logic o_cout
);

    assign o_shuma = i_a ^ i_b ^ i_cin;
    assign o_cout  = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// File: rtl/mbledhesi_serial.sv
// Bit-serial N-bit adder: feeds one operand bit pair per clock, LSB first, to
// a single full-adder cell and reports the registered sum with a DONE pulse.
module mbledhesi_serial
    import mbledhesi_serial_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         CIN0,
    output logic         BUSY,
    output logic         DONE,
    output logic [N-1:0] SHUMA,
    output logic         COUT,
    output state_t       o_dbg_state
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [N-1:0]  r_opa;
    logic [N-1:0]  r_opb;
    logic          r_carry;
    logic [N-1:0]  r_result;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_shuma;
    logic          r_cout;
    logic          w_fa_sum;
    logic          w_fa_cout;
    logic [N-1:0]  w_result_next;
    logic          w_last;

    mbledhesi_1b u_fa (
        .i_a     (r_opa[0]),
        .i_b     (r_opb[0]),
        .i_cin   (r_carry),
        .o_shuma (w_fa_sum),
        .o_cout  (w_fa_cout)
    );

    // New sum bit enters at the MSB; after N shifts bit 0 holds the first sum bit.
    assign w_result_next = N'({w_fa_sum, r_result} >> 1);
    assign w_last        = (r_cnt == LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        case (r_state)
            IDLE: begin
                if (START) w_next_state = SHIFT;
            end
            SHIFT: begin
                BUSY = 1'b1;
                if (w_last) w_next_state = FIN;
            end
            FIN: begin
                DONE         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_opa    <= '0;
            r_opb    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_cnt    <= '0;
            r_shuma  <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (START) begin
                        r_opa    <= A;
                        r_opb    <= B;
                        r_carry  <= CIN0;
                        r_result <= '0;
                        r_cnt    <= '0;
                    end
                end
                SHIFT: begin
                    r_carry  <= w_fa_cout;
                    r_result <= w_result_next;
                    r_opa    <= r_opa >> 1;
                    r_opb    <= r_opb >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    // Outputs move only on the FIN-entry edge so they hold through SHIFT.
                    if (w_last) begin
                        r_shuma <= w_result_next;
                        r_cout  <= w_fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign SHUMA       = r_shuma;
    assign COUT        = r_cout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mbledhesi_serial.sv
// Self-checking bench for the bit-serial adder (N=8 instance plus an N=1 instance),
// checked against plain integer addition and cycle-count expectations.
module tb_mbledhesi_serial;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin0;
    logic         busy;
    logic         done;
    logic [N-1:0] shuma;
    logic         cout;
    logic [1:0]   dbg;

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         cin1;
    logic         busy1;
    logic         done1;
    logic [0:0]   shuma1;
    logic         cout1;
    logic [1:0]   dbg1;

    int           vectors     = 0;
    int           miscompares = 0;
    logic [N-1:0] last_sum;
    logic         last_cout;

    always #5 clk = ~clk;

    mbledhesi_serial #(.N(N)) u_dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .A(a), .B(b), .CIN0(cin0),
        .BUSY(busy), .DONE(done), .SHUMA(shuma), .COUT(cout), .o_dbg_state(dbg)
    );

    mbledhesi_serial #(.N(1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1), .A(a1), .B(b1), .CIN0(cin1),
        .BUSY(busy1), .DONE(done1), .SHUMA(shuma1), .COUT(cout1), .o_dbg_state(dbg1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One addition on the N=8 instance. disturb pulses START and scrambles the
    // operands mid-operation; abort_at >= 0 pulls reset at that SHIFT cycle.
    task automatic run_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv,
                          input bit disturb, input int abort_at);
        logic [N:0] exp_full;
        exp_full = {1'b0, av} + {1'b0, bv} + {{N{1'b0}}, cv};
        @(negedge clk);
        a = av; b = bv; cin0 = cv; start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            start = disturb && (k == 2 || k == 5);
            if (start) begin
                a = N'($urandom); b = N'($urandom); cin0 = 1'($urandom);
            end
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_sum", shuma, 0);
                check("abort_cout", cout, 0);
                check("abort_state", dbg, 0);
                @(negedge clk);
                rst_n = 1'b1;
                last_sum = '0;
                last_cout = 1'b0;
                for (int j = 0; j < N + 2; j++) begin
                    @(negedge clk);
                    check("abort_no_done", done, 0);
                    check("abort_idle", busy, 0);
                end
                return;
            end
            check("shift_busy", busy, 1);
            check("shift_done", done, 0);
            check("shift_sum_hold", shuma, last_sum);
            check("shift_cout_hold", cout, last_cout);
        end
        @(negedge clk);
        start = 1'b0;
        check("fin_done", done, 1);
        check("fin_busy", busy, 0);
        check("fin_sum", shuma, exp_full[N-1:0]);
        check("fin_cout", cout, exp_full[N]);
        last_sum = exp_full[N-1:0];
        last_cout = exp_full[N];
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_sum_hold", shuma, last_sum);
    endtask

    task automatic run_op1(input logic av, input logic bv, input logic cv);
        logic [1:0] exp2;
        exp2 = {1'b0, av} + {1'b0, bv} + {1'b0, cv};
        @(negedge clk);
        a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        check("n1_busy", busy1, 1);
        check("n1_shift_done", done1, 0);
        @(negedge clk);
        check("n1_done", done1, 1);
        check("n1_busy_off", busy1, 0);
        check("n1_sum", shuma1, exp2[0]);
        check("n1_cout", cout1, exp2[1]);
        @(negedge clk);
        check("n1_done_off", done1, 0);
    endtask

    initial begin
        int n_done;
        int last_cyc;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin0 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        last_sum = '0; last_cout = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", shuma, 0);
        check("rst_cout", cout, 0);
        check("rst_state", dbg, 0);
        check("rst_n1_sum", shuma1, 0);
        rst_n = 1'b1;

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, -1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, -1);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, -1);
        run_op(8'h80, 8'h80, 1'b1, 1'b0, -1);
        run_op(8'hA5, 8'h0F, 1'b1, 1'b1, -1);
        run_op(8'h77, 8'h11, 1'b0, 1'b0, 4);
        run_op(8'h12, 8'h34, 1'b0, 1'b0, -1);

        // START held high: completions every N+2 cycles, sum stable in between.
        n_done = 0;
        last_cyc = 0;
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin0 = 1'b0; start = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (cyc == 39) start = 1'b0;
            if (done === 1'b1) begin
                if (n_done == 0) check("b2b_first", cyc, N);
                else check("b2b_gap", cyc - last_cyc, N + 2);
                n_done++;
                last_cyc = cyc;
            end
            if (n_done > 0) begin
                check("b2b_sum", shuma, 8'h02);
                check("b2b_cout", cout, 0);
            end else begin
                check("b2b_sum_hold", shuma, last_sum);
            end
        end
        check("b2b_count", n_done, 4);
        last_sum = 8'h02;
        last_cout = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom), 1'b0, -1);
        end

        for (int i = 0; i < 8; i++) begin
            run_op1(i[2], i[1], i[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mbledhesi_serial.md
Name: mbledhesi_serial

Overview:
- Bit-serial N-bit adder controller, built around the team's 1-bit full-adder cell.
- Captures two N-bit operands on a start request, presents one bit pair per clock (LSB first) to the full-adder cell, and registers the carry between cycles.
- Assembles the sum word and reports completion with a one-cycle DONE pulse.
- Sits between the operand source (register file / test sequencer) and the result consumer; trades N cycles of latency for a single adder cell.

Parameters:
- N, 8, operand and sum width in bits; legal range N >= 1.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  request to begin an addition; sampled only in IDLE.
- A  input  N  operand A; captured on the accepted START edge only.
- B  input  N  operand B; captured on the accepted START edge only.
- CIN0  input  1  initial carry-in; captured with A/B.
- BUSY  output  1  high while in SHIFT state.
- DONE  output  1  one-cycle pulse: SHUMA/COUT valid and newly updated.
- SHUMA  output  N  registered sum; holds value until the next completion.
- COUT  output  1  registered final carry-out; holds with SHUMA.

Behaviour:
- Reset: RST_N low forces state IDLE, BUSY=0, DONE=0, SHUMA=0, COUT=0, and clears the internal shift/carry/count registers. Applies immediately (asynchronous), including mid-operation; the aborted operation produces no DONE.
- FSM states: IDLE, SHIFT, FIN.
- IDLE, START=1 at edge E0: load opA<=A, opB<=B, carry<=CIN0, cnt<=0, result<=0; go to SHIFT.
- IDLE, START=0: stay in IDLE.
- SHIFT, each edge:
  - Full-adder inputs: A=opA[0], B=opB[0], CIN=carry.
  - carry<=full-adder COUT.
  - result<={full-adder SHUMA, result[N-1:1]}.
  - opA and opB shift right by 1; cnt<=cnt+1.
- SHIFT, edge with cnt==N-1: besides the normal shift, load SHUMA<={sum bit, result[N-1:1]} and COUT<=full-adder COUT; go to FIN.
- FIN: DONE=1 for exactly one cycle, then unconditional return to IDLE.
- Latency: START accepted at E0; DONE high in the cycle after edge E0+N; next START accepted at edge E0+N+2. Minimum issue period is N+2 cycles.
- Output decode: BUSY=1 only in SHIFT; DONE=1 only in FIN. Both are decoded from registered state (glitch-free, no combinational path from inputs).
- START rules:
  - START in SHIFT or FIN is ignored; it is not queued.
  - START held high continuously gives back-to-back operations every N+2 cycles.
- A/B/CIN0 changes after the START edge have no effect on the operation in progress.
- SHUMA/COUT are not disturbed during SHIFT; they change only on the FIN-entry edge.
- Arithmetic: {COUT,SHUMA} = A + B + CIN0, modulo 2^(N+1); no overflow flag.
- Counter width is max(1, clog2(N)). For N=1 the terminal condition holds on the first SHIFT edge, giving exactly one SHIFT cycle.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, SHIFT=2'd1, FIN=2'd2) and a helper for counter width.
- One sub-module, mbledhesi_1b (existing full-adder cell), instantiated once: inputs opA[0], opB[0], carry; outputs feed carry and result.
- All sequencing stays in mbledhesi_serial.

Test Plan:
- N=8, A=8'h5A, B=8'h3C, CIN0=0, 1-cycle START -> BUSY high for 8 cycles; DONE pulses in cycle 9 after the START edge; SHUMA=8'h96, COUT=0.
- A=8'hFF, B=8'h01, CIN0=0 -> SHUMA=8'h00, COUT=1. Then A=8'hFF, B=8'h00, CIN0=1 -> SHUMA=8'h00, COUT=1. Then A=8'h80, B=8'h80, CIN0=1 -> SHUMA=8'h01, COUT=1.
- Pulse START again and change A/B at cycles 2 and 5 of SHIFT -> both START pulses ignored; result reflects the operands captured originally; exactly one DONE.
- Assert RST_N low at cycle 4 of SHIFT -> all outputs 0 immediately, no DONE. After release, START with A=8'h12, B=8'h34 -> SHUMA=8'h46, COUT=0.
- Hold START=1 continuously with A=8'h01, B=8'h01 -> DONE every 10 cycles; SHUMA=8'h02 each time; SHUMA stable between pulses.
- N=1 build, A=1, B=1, CIN0=1 -> one BUSY cycle, DONE next cycle, SHUMA=1, COUT=1.
